// File: rtl/shift_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
package shift_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_t;

endpackage

// File: rtl/shift_deser_shreg.sv
// Bidirectional serial-in register. Clear has priority over shift.
// o_shift is the value the register would take on a shift this edge,
// which lets the owner capture a completed word including the bit in flight.
module deser_shreg
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_shift
);

  logic [WIDTH-1:0] r_sr;

  // Next-shift value: LSB-first enters at the top and walks down to bit 0,
  // MSB-first enters at the bottom and walks up to bit WIDTH-1.
  always_comb begin
    o_shift = r_sr;
    if (i_dir == DIR_MSB_FIRST) o_shift = {r_sr[WIDTH-2:0], i_sin};
    else                        o_shift = {i_sin, r_sr[WIDTH-1:1]};
  end

  // Register update: reset/clear, else shift when enabled.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) r_sr <= '0;
    else if (i_en)        r_sr <= o_shift;
  end

  assign o_q = r_sr;

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: FSM, bit counter, single-entry output buffer
// and sticky overrun flag around a deser_shreg.
module shift_deser
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic             i_sin,
  input  logic             i_sin_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_data_valid,
  input  logic             i_data_ready,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  deser_state_t     r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;

  logic             w_sample;
  logic             w_done;
  logic             w_shift;
  logic             w_drain;
  logic [WIDTH-1:0] w_sr_q;
  logic [WIDTH-1:0] w_word;

  // A bit is sampled only while receiving. The final bit completes the frame
  // even when start arrives on the same edge (zero-gap back-to-back); any
  // other bit coinciding with start is dropped because start wins.
  assign w_sample = (r_state == RECV) && i_sin_valid;
  assign w_done   = w_sample && (r_cnt == LAST);
  assign w_shift  = w_sample && !i_start;
  assign w_drain  = r_valid && i_data_ready;

  deser_shreg #(.WIDTH(WIDTH)) u_shreg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_start),
    .i_en    (w_shift),
    .i_dir   (r_dir),
    .i_sin   (i_sin),
    .o_q     (w_sr_q),
    .o_shift (w_word)
  );

  // FSM and bit counter; start restarts from any state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_LSB_FIRST;
    end else if (i_start) begin
      r_state <= RECV;
      r_cnt   <= '0;
      r_dir   <= i_dir;
    end else if (w_done) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Output buffer: load when empty or draining this edge, else drop and flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_done) begin
      if (!r_valid || w_drain) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_valid;
  assign o_busy       = (r_state == RECV);
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_shift_deser.sv
// Directed self-checking bench for shift_deser.
module tb_shift_deser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       busy;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_deser #(.WIDTH(8)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_dir        (dir),
    .i_sin        (sin),
    .i_sin_valid  (sin_valid),
    .o_data       (data),
    .o_data_valid (data_valid),
    .i_data_ready (data_ready),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  // Inputs change at negedge; outputs are read at the following negedge.
  task automatic do_reset();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
  endtask

  task automatic do_start(input logic d);
    start = 1'b1; dir = d; @(negedge clk); start = 1'b0;
  endtask

  // Send bit positions k_from..k_to of b in the order implied by d.
  task automatic send_bits(input logic [7:0] b, input logic d,
                           input int k_from, input int k_to, input int gap);
    for (int k = k_from; k <= k_to; k++) begin
      sin = d ? b[7-k] : b[k];
      sin_valid = 1'b1;
      @(negedge clk);
      sin_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drain();
    data_ready = 1'b1; @(negedge clk); data_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data); end
    n_tests++; if ({data_valid, busy, overrun} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags got v/b/o=%b exp=000", {data_valid, busy, overrun}); end
  endtask

  task automatic test_lsb_first();
    do_start(1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lsb_busy got=%b exp=1", busy); end
    send_bits(8'h4D, 1'b0, 0, 6, 0);
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_early_valid got=%b exp=0", data_valid); end
    send_bits(8'h4D, 1'b0, 7, 7, 0);
    n_tests++; if (data_valid !== 1'b1 || data !== 8'h4D) begin n_fail++;
      $display("FAIL lsb_word got v=%b d=%h exp v=1 d=4d", data_valid, data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lsb_busy_end got=%b exp=0", busy); end
    drain();
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_drain got=%b exp=0", data_valid); end
  endtask

  task automatic test_msb_first();
    do_start(1'b1);
    send_bits(8'h4D, 1'b0, 0, 7, 0);   // same wire sequence 1,0,1,1,0,0,1,0
    n_tests++; if (data_valid !== 1'b1 || data !== 8'hB2) begin n_fail++;
      $display("FAIL msb_word got v=%b d=%h exp v=1 d=b2", data_valid, data); end
    drain();
    do_start(1'b1);
    send_bits(8'h4D, 1'b0, 0, 6, 2);
    n_tests++; if (busy !== 1'b1 || data_valid !== 1'b0) begin n_fail++;
      $display("FAIL msb_gap_hold got b=%b v=%b exp b=1 v=0", busy, data_valid); end
    send_bits(8'h4D, 1'b0, 7, 7, 0);
    n_tests++; if (data_valid !== 1'b1 || data !== 8'hB2) begin n_fail++;
      $display("FAIL msb_gap_word got v=%b d=%h exp v=1 d=b2", data_valid, data); end
    drain();
  endtask

  task automatic test_overrun();
    do_start(1'b0); send_bits(8'hA5, 1'b0, 0, 7, 0);
    do_start(1'b1); send_bits(8'h3C, 1'b1, 0, 7, 0);
    n_tests++; if (data !== 8'hA5 || data_valid !== 1'b1) begin n_fail++;
      $display("FAIL ovr_keep got v=%b d=%h exp v=1 d=a5", data_valid, data); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    drain();
    n_tests++; if (data_valid !== 1'b0 || overrun !== 1'b1) begin n_fail++;
      $display("FAIL ovr_sticky got v=%b o=%b exp v=0 o=1", data_valid, overrun); end
    do_reset();
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_drain_on_write();
    do_start(1'b0); send_bits(8'h11, 1'b0, 0, 7, 0);
    do_start(1'b0); send_bits(8'h22, 1'b0, 0, 6, 0);
    data_ready = 1'b1;
    send_bits(8'h22, 1'b0, 7, 7, 0);
    data_ready = 1'b0;
    n_tests++; if (data !== 8'h22 || data_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++;
      $display("FAIL drain_write got d=%h v=%b o=%b exp d=22 v=1 o=0", data, data_valid, overrun); end
    drain();
  endtask

  task automatic test_restart();
    do_start(1'b0); send_bits(8'hFF, 1'b0, 0, 4, 0);
    start = 1'b1; dir = 1'b1; sin = 1'b1; sin_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; sin_valid = 1'b0;
    n_tests++; if (busy !== 1'b1 || data_valid !== 1'b0) begin n_fail++;
      $display("FAIL restart_busy got b=%b v=%b exp b=1 v=0", busy, data_valid); end
    send_bits(8'hF0, 1'b1, 0, 7, 0);
    n_tests++; if (data !== 8'hF0 || data_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++;
      $display("FAIL restart_word got d=%h v=%b o=%b exp d=f0 v=1 o=0", data, data_valid, overrun); end
    drain();
  endtask

  task automatic test_back_to_back();
    do_start(1'b0); send_bits(8'h5A, 1'b0, 0, 6, 0);
    start = 1'b1; dir = 1'b1;
    send_bits(8'h5A, 1'b0, 7, 7, 0);
    start = 1'b0;
    n_tests++; if (data !== 8'h5A || data_valid !== 1'b1 || busy !== 1'b1) begin n_fail++;
      $display("FAIL b2b_first got d=%h v=%b b=%b exp d=5a v=1 b=1", data, data_valid, busy); end
    data_ready = 1'b1;
    send_bits(8'hC3, 1'b1, 0, 0, 0);
    data_ready = 1'b0;
    send_bits(8'hC3, 1'b1, 1, 7, 0);
    n_tests++; if (data !== 8'hC3 || data_valid !== 1'b1 || overrun !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL b2b_second got d=%h v=%b o=%b b=%b exp d=c3 v=1 o=0 b=0", data, data_valid, overrun, busy); end
    drain();
  endtask

  task automatic test_reset_mid();
    do_start(1'b0); send_bits(8'h55, 1'b0, 0, 7, 0);
    do_start(1'b0); send_bits(8'h0F, 1'b0, 0, 3, 0);
    do_reset();
    n_tests++; if (data !== 8'h00 || {data_valid, busy, overrun} !== 3'b000) begin n_fail++;
      $display("FAIL reset_mid got d=%h v/b/o=%b exp d=00 v/b/o=000", data, {data_valid, busy, overrun}); end
    send_bits(8'hFF, 1'b0, 0, 7, 0);
    n_tests++; if (data_valid !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL idle_ignore got v=%b b=%b exp v=0 b=0", data_valid, busy); end
    // a fresh frame after reset must start cleanly from bit 0
    do_start(1'b0); send_bits(8'h81, 1'b0, 0, 7, 0);
    n_tests++; if (data !== 8'h81 || data_valid !== 1'b1) begin n_fail++;
      $display("FAIL post_reset got d=%h v=%b exp d=81 v=1", data, data_valid); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_overrun();
    test_drain_on_write();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
